// File: rtl/ro_puf_ctrl_if.sv
// ro_puf_ctrl_if: challenge/response bus between a host and ro_puf_ctrl.
// PUF_TIE_FLAG_EN adds the tie result flag.
interface ro_puf_ctrl_if #(
   parameter int SEL_W = 3,
   parameter int CNT_W = 16
);
   logic               start;
   logic [2*SEL_W-1:0] challenge;
   logic               busy;
   logic               done;
   logic               response;
   logic               err;
   logic [CNT_W-1:0]   count_a;
   logic [CNT_W-1:0]   count_b;
`ifdef PUF_TIE_FLAG_EN
   logic               tie;
   modport master (output start, challenge, input busy, done, response, err, count_a, count_b, tie);
   modport slave  (input start, challenge, output busy, done, response, err, count_a, count_b, tie);
`else
   modport master (output start, challenge, input busy, done, response, err, count_a, count_b);
   modport slave  (input start, challenge, output busy, done, response, err, count_a, count_b);
`endif
endinterface

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: ring-oscillator PUF sequencer (settle, count window, compare) giving one response bit per challenge.
// Optional PUF_TIE_FLAG_EN adds a tie flag pulsed with done on equal counts.
module ro_puf_ctrl #(
   parameter int NUM_RO = 8,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 16,
   parameter int SETTLE = 4,
   parameter int WINDOW = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_RO-1:0] ro_in,
   output logic [NUM_RO-1:0] ro_en,
   ro_puf_ctrl_if.slave      bus
);
   localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_DONE} state_t;
   state_t            state, state_n;
   logic [TW-1:0]     tmr, tmr_n;
   logic [SEL_W-1:0]  ch_a, ch_b, sel_a, sel_b;
   logic              ch_ok, bad, accept, run_n;
   logic [NUM_RO-1:0] mask_n, sync1, sync2, prev, rise;
   logic [CNT_W-1:0]  cnt_a, cnt_b;

   function automatic logic [NUM_RO-1:0] pair(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b);
      return (NUM_RO'(1) << a) | (NUM_RO'(1) << b);
   endfunction

   assign ch_a        = bus.challenge[2*SEL_W-1:SEL_W];
   assign ch_b        = bus.challenge[SEL_W-1:0];
   assign ch_ok       = ch_a != ch_b && 32'(ch_a) < NUM_RO && 32'(ch_b) < NUM_RO;
   assign rise        = sync2 & ~prev;
   assign bus.busy    = state != S_IDLE;
   assign bus.count_a = cnt_a;
   assign bus.count_b = cnt_b;

   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else begin
         state <= state_n;
         tmr   <= tmr_n;
      end

   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      accept  = 1'b0;
      case (state)
         S_IDLE:
            if (bus.start) begin
               accept  = 1'b1;
               state_n = ch_ok ? S_SETTLE : S_DONE;
               tmr_n   = TW'(SETTLE - 1);
            end
         S_SETTLE: begin
            tmr_n = tmr - 1'b1;
            if (tmr == '0) begin
               state_n = S_COUNT;
               tmr_n   = TW'(WINDOW - 1);
            end
         end
         S_COUNT: begin
            tmr_n   = tmr - 1'b1;
            state_n = (tmr == '0) ? S_DONE : S_COUNT;
         end
         default: state_n = S_IDLE;
      endcase
      run_n  = state_n == S_SETTLE || state_n == S_COUNT;
      mask_n = accept ? pair(ch_a, ch_b) : pair(sel_a, sel_b);
   end

   // enables are registered so the oscillator array sees glitch-free levels
   always_ff @(posedge clk)
      if (!rst_n) begin
         sel_a <= '0;
         sel_b <= '0;
         bad   <= 1'b0;
         ro_en <= '0;
      end else begin
         if (accept) {sel_a, sel_b, bad} <= {ch_a, ch_b, !ch_ok};
         ro_en <= run_n ? mask_n : '0;
      end

   always_ff @(posedge clk)
      if (!rst_n) {sync1, sync2, prev} <= '0;
      else {sync1, sync2, prev} <= {ro_in, sync1, sync2};

   // counting is gated by state, so edges still in the synchroniser at exit are lost
   always_ff @(posedge clk)
      if (!rst_n || accept) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (state == S_COUNT) begin
         if (rise[sel_a] && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
         if (rise[sel_b] && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
      end

   always_ff @(posedge clk)
      if (!rst_n || accept) begin
         bus.done     <= 1'b0;
         bus.response <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.done <= state == S_DONE;
         if (state == S_DONE) begin
            bus.err      <= bad;
            bus.response <= !bad && cnt_a > cnt_b;
         end
      end

`ifdef PUF_TIE_FLAG_EN
   always_ff @(posedge clk)
      bus.tie <= rst_n && state == S_DONE && !bad && cnt_a == cnt_b;
`endif
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: directed bench for ro_puf_ctrl with behavioural ring oscillators gated by ro_en.
// Time unit scale: 10 units = 1 ns (clk period 20 = 2 ns).
module tb_ro_puf_ctrl;
   localparam int S = 4, W = 100;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] ro_in, ro_en, ro_s, ro_en_s;
   int         half [8] = '{50, 50, 50, 50, 50, 50, 50, 50};
   int         tests = 0, fails = 0;

   ro_puf_ctrl_if #(.SEL_W(3), .CNT_W(16)) m ();
   ro_puf_ctrl_if #(.SEL_W(3), .CNT_W(4))  s ();

   ro_puf_ctrl #(.NUM_RO(8), .SEL_W(3), .CNT_W(16), .SETTLE(S), .WINDOW(W)) dut (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en), .bus(m.slave));
   ro_puf_ctrl #(.NUM_RO(8), .SEL_W(3), .CNT_W(4), .SETTLE(S), .WINDOW(W)) sat (
      .clk(clk), .rst_n(rst_n), .ro_in(ro_s), .ro_en(ro_en_s), .bus(s.slave));

   always #10 clk = ~clk;

   // oscillators derived from absolute time so equal periods stay phase-locked; transitions never hit a clk edge
   always begin
      #1;
      for (int i = 0; i < 8; i++) begin
         ro_in[i] = ro_en[i] & ((((int'($time) + 3) / half[i]) % 2) == 1);
         ro_s[i]  = ro_en_s[i] & ((((int'($time) + 3) / 20) % 2) == 1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic eval(input logic [5:0] ch, input logic [7:0] mask, output int lat, output logic en_ok);
      @(negedge clk);
      m.start     = 1'b1;
      m.challenge = ch;
      @(negedge clk);
      m.start = 1'b0;
      lat     = 0;
      en_ok   = 1'b1;
      while (!m.done && lat < 400) begin
         if (ro_en !== ((lat < S + W) ? mask : 8'h00)) en_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int   lat, n;
      logic ok;
      m.start = 1'b0; m.challenge = '0;
      s.start = 1'b0; s.challenge = '0;
      repeat (3) @(negedge clk);
      chk("rst_ro_en", ro_en, 0);
      chk("rst_busy", m.busy, 0);
      chk("rst_done", m.done, 0);
      chk("rst_resp", m.response, 0);
      chk("rst_err", m.err, 0);
      chk("rst_cnt_a", m.count_a, 0);
      chk("rst_cnt_b", m.count_b, 0);
      rst_n = 1'b1;

      half[3] = 50; half[5] = 70;
      eval(6'o35, 8'h28, lat, ok);
      chk("basic_lat", lat, S + W + 1);
      chk("basic_ro_en", ok, 1);
      chk("basic_cnt_a_20", m.count_a >= 19 && m.count_a <= 21, 1);
      chk("basic_cnt_b_14", m.count_b >= 13 && m.count_b <= 15, 1);
      chk("basic_resp", m.response, 1);
      chk("basic_err", m.err, 0);
      chk("basic_busy", m.busy, 0);
      chk("basic_en_off", ro_en, 0);
`ifdef PUF_TIE_FLAG_EN
      chk("basic_tie", m.tie, 0);
`endif
      @(negedge clk);
      chk("done_pulse", m.done, 0);
      chk("hold_resp", m.response, 1);
      chk("hold_cnt_a", m.count_a >= 19 && m.count_a <= 21, 1);

      eval(6'o53, 8'h28, lat, ok);
      chk("swap_lat", lat, S + W + 1);
      chk("swap_resp", m.response, 0);
      chk("swap_cnt_a", m.count_a >= 13 && m.count_a <= 15, 1);
      chk("swap_cnt_b", m.count_b >= 19 && m.count_b <= 21, 1);

      eval(6'o22, 8'h00, lat, ok);
      chk("inv_lat", lat, 1);
      chk("inv_ro_en", ok, 1);
      chk("inv_err", m.err, 1);
      chk("inv_resp", m.response, 0);
      chk("inv_cnt_a", m.count_a, 0);

      // second start inside the counting window must be ignored
      @(negedge clk); m.challenge = 6'o35; m.start = 1'b1;
      @(negedge clk); m.start = 1'b0;
      chk("accept_clears_err", m.err, 0);
      repeat (50) @(negedge clk);
      m.start = 1'b1;
      @(negedge clk); m.start = 1'b0;
      n = 0;
      repeat (200) begin
         @(negedge clk);
         n += 32'(m.done);
      end
      chk("single_done", n, 1);

      @(negedge clk); m.start = 1'b1;
      @(negedge clk); m.start = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_ro_en", ro_en, 8'h28);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("abort_ro_en", ro_en, 0);
      chk("abort_busy", m.busy, 0);
      chk("abort_cnt_a", m.count_a, 0);
      n = 0;
      repeat (150) begin
         @(negedge clk);
         n += 32'(m.done);
      end
      chk("abort_no_done", n, 0);

      // start held high: done, one IDLE cycle, done again
      m.challenge = 6'o22; m.start = 1'b1;
      lat = 0;
      while (!m.done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m.done && n < 10);
      chk("b2b_gap", n, 2);
      m.start = 1'b0;
      repeat (4) @(negedge clk);

      @(negedge clk); s.challenge = 6'o10; s.start = 1'b1;
      @(negedge clk); s.start = 1'b0;
      lat = 0;
      while (!s.done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk("sat_lat", lat, S + W + 1);
      chk("sat_cnt_a", s.count_a, 15);
      chk("sat_cnt_b", s.count_b, 15);
      chk("sat_resp", s.response, 0);

      half[5] = 50;
      eval(6'o35, 8'h28, lat, ok);
      chk("eq_lat", lat, S + W + 1);
      chk("eq_resp", m.response, 0);
      chk("eq_cnt_a", m.count_a >= 19 && m.count_a <= 21, 1);
`ifdef PUF_TIE_FLAG_EN
      chk("eq_tie", m.tie, 1);
      @(negedge clk);
      chk("tie_pulse", m.tie, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
